// File: rtl/stego_lsb_extractor.sv
// stego_lsb_extractor: recovers a hidden message from the LSBs of a stego pixel
// stream. Bits are packed MSB-first into bytes. The bytes are queued in a show-ahead
// FIFO and handed out over a valid/ready handshake.
// Optional feature: define STEGO_CHECKSUM_EN to add msg_checksum, the running XOR
// of every byte recovered in the current run.
module stego_lsb_extractor #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    output logic             pix_ready,
    output logic             msg_valid,
    output logic [7:0]       msg_byte,
    input  logic             msg_ready,
    output logic             busy,
    output logic             done
`ifdef STEGO_CHECKSUM_EN
    ,
    output logic [7:0]       msg_checksum
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXTRACT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [7:0]       csum_q, csum_d;

    logic       fifo_full, fifo_empty;
    logic       accept, push, pop, last_byte;
    logic [7:0] new_byte;
    logic       unused_pix_hi;

    // FIFO status, handshakes and the byte being completed this cycle
    always_comb begin
        fifo_empty    = (wr_ptr_q == rd_ptr_q);
        fifo_full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pix_ready     = (state_q == S_EXTRACT) && !fifo_full;
        accept        = pix_valid && pix_ready;
        push          = accept && (bit_cnt_q == 3'd7);
        new_byte      = {shreg_q, pix_data[0]};
        last_byte     = push && ((byte_cnt_q + LEN_W'(1)) == len_q);
        msg_valid     = !fifo_empty;
        msg_byte      = mem_q[rd_ptr_q[AW-1:0]];
        pop           = msg_valid && msg_ready;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        unused_pix_hi = ^pix_data[7:1];
    end

    // Next-state: run control, bit assembly, FIFO pointers and storage
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        csum_d     = csum_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = new_byte;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = msg_len;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    state_d    = (msg_len == '0) ? S_DONE : S_EXTRACT;
                end
            end
            S_EXTRACT: begin
                if (accept) begin
                    shreg_d   = {shreg_q[5:0], pix_data[0]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                if (push) begin
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    csum_d     = csum_q ^ new_byte;
                end
                if (last_byte) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards partial bits and any buffered bytes
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            csum_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            csum_q     <= csum_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef STEGO_CHECKSUM_EN
    // Checksum output reflects the running XOR register directly
    always_comb begin
        msg_checksum = csum_q;
    end
`endif

endmodule
